// File: rtl/nios2test_pio_pkg.sv
// nios2test_pio_pkg
//   Shared constants for the nios2test parallel input port: register word
//   addresses and the encodings of the capture-edge selector.
//   No ports (package only).
package nios2test_pio_pkg;

  // Register word addresses (word 1 is reserved and reads as zero)
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios2test_sync2.sv
// nios2test_sync2
//   Two-flop synchronizer for a bus of independent asynchronous bits.
//   Each bit is synchronized on its own; no multi-bit coherency is implied.
// Ports:
//   clk   - sampling clock (rising edge)
//   reset - asynchronous active-high reset, clears both stages
//   d     - asynchronous input bus, WIDTH bits
//   q     - synchronized output bus, WIDTH bits (two clocks of latency)
module nios2test_sync2 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Stage boundary: meta_q may go metastable, sync_q is the clean copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nios2test_pio_in.sv
// nios2test_pio_in
//   Memory-mapped parallel input port with per-bit edge capture and a
//   maskable level interrupt.
//   Register map: 0 data_in (RO), 1 reserved (reads 0), 2 irq_mask (RW),
//   3 edge_capture (read, write-to-clear).
//   Build option: define NIOS2TEST_PIO_IN_BIT_CLEAR_EN so a write to word 3
//   clears only the bits written as 1; otherwise any write clears all bits.
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   address    - register word select (2 bits)
//   chipselect - qualifies every access
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data
//   in_port    - WIDTH-bit input, asynchronous to clk
//   readdata   - 32-bit combinational read data, zero-extended
//   irq        - active-high level interrupt
module nios2test_pio_in
  import nios2test_pio_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits have no destination when WIDTH < 32
  assign unused_wdata = ^writedata;

  nios2test_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_w)
  );

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~sync_w & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = sync_w ^ prev_q;
    end else begin
      edge_det = sync_w & ~prev_q;
    end
  end

`ifdef NIOS2TEST_PIO_IN_BIT_CLEAR_EN
  assign clr_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
`else
  assign clr_bits = (wr_en && address == ADDR_EDGE) ? {WIDTH{1'b1}} : '0;
`endif

  always_comb begin
    prev_d     = sync_w;
    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // OR-ing the new edges in after the clear lets a same-cycle set win
    edge_capture_d = (edge_capture_q & ~clr_bits) | edge_det;
  end

  // Stage boundary: edge history, mask and sticky capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(sync_w);
      ADDR_MASK: readdata = 32'(irq_mask_q);
      ADDR_EDGE: readdata = 32'(edge_capture_q);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: doc/nios2test_pio_in.md
NIOS2TEST_PIO_IN -- requirements
Module: nios2test_pio_in

Interface
REQ-001 The block SHALL take parameter WIDTH, default 10, giving the input port width (1..32).
REQ-002 The block SHALL take parameter EDGE_TYPE, default 0, selecting capture edge: 0 rising, 1 falling, 2 any.
REQ-003 Port clk SHALL be an input, 1 bit, and is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous, active-high.
REQ-005 Port address SHALL be an input, 2 bits, selecting the register word.
REQ-006 Port chipselect SHALL be an input, 1 bit, and qualifies every access.
REQ-007 Port write_n SHALL be an input, 1 bit, active-low write strobe.
REQ-008 Port writedata SHALL be an input, 32 bits, carrying write data.
REQ-009 Port in_port SHALL be an input, WIDTH bits, asynchronous to clk.
REQ-010 Port readdata SHALL be an output, 32 bits, carrying read data.
REQ-011 Port irq SHALL be an output, 1 bit, active-high level interrupt.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer (sync) followed by one delay flop (prev); data_in = sync.
REQ-013 An edge SHALL be detected when sync & ~prev (rising), ~sync & prev (falling), or sync ^ prev (any), per bit, per EDGE_TYPE.
REQ-014 A change on in_port bit sampled at edge n SHALL appear in sync at edge n+2 and set edge_capture at edge n+3.
REQ-015 Register map SHALL be: 0 data_in (RO); 1 reserved (reads 0, writes ignored); 2 irq_mask (RW, WIDTH bits); 3 edge_capture (read, write-to-clear).
REQ-016 readdata SHALL be combinational from address, zero-extended above WIDTH, with zero read latency; reserved bits read 0.
REQ-017 A write SHALL occur when chipselect && ~write_n; writes to address 0 or 1 SHALL have no effect.
REQ-018 irq_mask SHALL load writedata[WIDTH-1:0] on a write to address 2.
REQ-019 edge_capture bits SHALL be sticky until cleared by a write to address 3.
REQ-020 When a detected edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-021 irq SHALL equal |(edge_capture & irq_mask), combinational from registers.
REQ-022 Writing irq_mask SHALL affect irq in the cycle following the write edge.

Reset
REQ-023 reset SHALL asynchronously clear sync, prev, irq_mask and edge_capture to 0, giving irq = 0 and readdata = 0 for address 2/3.
REQ-024 A bit held high across reset release SHALL be captured as a rising edge (EDGE_TYPE 0/2) three edges after release; this is intended behaviour.
REQ-025 Reset asserted mid-operation SHALL discard pending edges and mask with no other side effect.

Configuration
REQ-026 Macro NIOS2TEST_PIO_IN_BIT_CLEAR_EN SHALL select the clear mode for edge_capture.
REQ-027 With the macro defined, a write to address 3 SHALL clear only the bits where writedata is 1.
REQ-028 Without the macro, any write to address 3 SHALL clear all bits regardless of writedata.

Structure
REQ-029 Package nios2test_pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) and the EDGE_TYPE encodings.
REQ-030 The synchronizer SHALL be a sub-module nios2test_sync2 (WIDTH-parameterised, 2 flops, async active-high reset).

Verification
REQ-031 in_port 0x000->0x2A5 with no accesses -> address 0 reads 0x2A5 from edge n+2, 0x000 before.
REQ-032 EDGE_TYPE=0, mask 0x001, pulse bit 0 high for 3 clocks -> edge_capture=0x001 at n+3, irq=1; falling edge does not set further bits.
REQ-033 edge_capture=0x003, write 0x001 to address 3 -> macro defined: reads 0x002, irq stays up if bit 1 masked; macro undefined: reads 0x000, irq=0.
REQ-034 Clear write to address 3 on the same cycle a new edge on bit 4 is detected -> bit 4 remains 1 afterwards.
REQ-035 EDGE_TYPE=2, toggle bit 9 twice, mask 0 -> edge_capture=0x200, irq=0; then write mask 0x200 -> irq=1 next cycle.
REQ-036 Assert reset while edge_capture=0x3FF and mask=0x3FF -> irq=0 and all registers read 0 immediately; write to address 1 -> no register changes.
